// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared encodings for the front-panel key command controller
package key_pkg;

  localparam int CNT_W = 26;

  localparam logic [1:0] CMD_SHORT  = 2'b01;
  localparam logic [1:0] CMD_LONG   = 2'b10;
  localparam logic [1:0] CMD_REPEAT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_HOLD   = 3'b010,
    ST_REPEAT = 3'b100
  } state_e;

endpackage

// File: rtl/key_prio_enc.sv
// rtl/key_prio_enc.sv - lowest-index-first priority encoder
// Ports: req (request vector), hit (any request), idx (lowest asserted index)
module key_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest asserted index is written last.
  always_comb begin
    hit = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/key_cmd_ctrl.sv
// rtl/key_cmd_ctrl.sv - classifies key holds into SHORT/LONG/REPEAT commands
// Ports: clk, rst (sync, active-high); key_flag/key_state (debounced events);
//        cmd_valid/cmd_ready/cmd_key/cmd_type (command handshake);
//        cmd_drop (command lost to backpressure); busy (a key is owned)
module key_cmd_ctrl
  import key_pkg::*;
#(
  parameter int               NUM_KEYS   = 4,
  parameter logic [CNT_W-1:0] LONG_MAX   = 26'd49_999_999,
  parameter logic [CNT_W-1:0] REPEAT_MAX = 26'd9_999_999,
  localparam int              KW         = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_state,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [KW-1:0]       cmd_key,
  output logic [1:0]          cmd_type,
  output logic                cmd_drop,
  output logic                busy
);

  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] rel_vec;
  logic                press_hit;
  logic [KW-1:0]       press_idx;

  state_e              state_q, state_d;
  logic [KW-1:0]       owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [KW-1:0]       cmd_key_q, cmd_key_d;
  logic [1:0]          cmd_type_q, cmd_type_d;
  logic                cmd_drop_q, cmd_drop_d;
  logic                busy_q;

  logic                owner_rel;
  logic                emit;
  logic [1:0]          emit_type;

  assign press_vec = key_flag & ~key_state;
  assign rel_vec   = key_flag & key_state;
  assign owner_rel = rel_vec[owner_q];

  key_prio_enc #(
    .N     (NUM_KEYS),
    .IDX_W (KW)
  ) u_prio (
    .req (press_vec),
    .hit (press_hit),
    .idx (press_idx)
  );

  // Ownership FSM and hold counter. Release of the owner always wins over a
  // threshold match in the same cycle; non-owner events are simply dropped.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_type = CMD_SHORT;
    unique case (state_q)
      ST_IDLE: begin
        if (press_hit) begin
          owner_d = press_idx;
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (owner_rel) begin
          emit      = 1'b1;
          emit_type = CMD_SHORT;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else if (cnt_q == LONG_MAX) begin
          emit      = 1'b1;
          emit_type = CMD_LONG;
          state_d   = ST_REPEAT;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (owner_rel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_MAX) begin
          emit      = 1'b1;
          emit_type = CMD_REPEAT;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Single-entry output slot: a new command may overwrite only an empty slot
  // or one being accepted this cycle; otherwise it is dropped and flagged.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_key_d   = cmd_key_q;
    cmd_type_d  = cmd_type_q;
    cmd_drop_d  = 1'b0;
    if (emit) begin
      if (!cmd_valid_q || cmd_ready) begin
        cmd_valid_d = 1'b1;
        cmd_key_d   = owner_q;
        cmd_type_d  = emit_type;
      end else begin
        cmd_drop_d = 1'b1;
      end
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_key_q   <= '0;
      cmd_type_q  <= 2'b00;
      cmd_drop_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_key_q   <= cmd_key_d;
      cmd_type_q  <= cmd_type_d;
      cmd_drop_q  <= cmd_drop_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_key   = cmd_key_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_drop  = cmd_drop_q;
  assign busy      = busy_q;

endmodule
